// File: rtl/mod5_pkg.sv
// mod5_pkg: shared state encoding and mod-5 position constants
package mod5_pkg;
  typedef enum logic [1:0] {IDLE, SEEK, FIN, GAPW} state_t;
  localparam int MOD = 5;
  localparam logic [2:0] POS_MAX = 3'd4;
endpackage

// File: rtl/mod5_dir.sv
// mod5_dir: shortest-path direction and enable between two mod-5 positions
module mod5_dir
  import mod5_pkg::*;
(
  input  logic [2:0] pos,
  input  logic [2:0] target,
  output logic       en,
  output logic       up
);
  logic [3:0] d;
  // forward distance (target - pos) mod 5; 1..2 is shorter going up, 3..4 going down
  always_comb begin
    d = {1'b0, target} + (target >= pos ? 4'd0 : 4'(MOD)) - {1'b0, pos};
    en = d != 4'd0;
    up = d == 4'd1 || d == 4'd2;
  end
endmodule

// File: rtl/mod5_seek_arb.sv
// mod5_seek_arb: round-robin arbiter steering a mod-5 up/down counter to a requester's target
module mod5_seek_arb
  import mod5_pkg::*;
#(
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [2:0] tgt0,
  input  logic [2:0] tgt1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic [2:0] pos,
  output logic       busy
);
  state_t state, nxt;
  logic [2:0] tgt, gcnt;
  logic own, rr, e0, e1, pick, en, up;
  mod5_dir u_dir (.pos(pos), .target(tgt), .en(en), .up(up));
  assign e0 = req[0] && tgt0 <= POS_MAX;
  assign e1 = req[1] && tgt1 <= POS_MAX;
  // rr holds the last served requester, so on contention the other one wins
  assign pick = (e0 && e1) ? !rr : e1;
  // next state and outputs, all decoded from registered state (err also looks at live req/targets)
  always_comb begin
    nxt = state == IDLE ? ((e0 || e1) ? SEEK : IDLE)
        : state == SEEK ? (!req[own] ? (GAP == 0 ? IDLE : GAPW) : (en ? SEEK : FIN))
        : state == FIN  ? (GAP == 0 ? IDLE : GAPW)
        : (int'(gcnt) == GAP - 1 ? IDLE : GAPW);
    gnt = (state == SEEK || state == FIN) ? (own ? 2'b10 : 2'b01) : 2'b00;
    done = state == FIN ? gnt : 2'b00;
    err = (state == IDLE && !rst) ? {req[1] && tgt1 > POS_MAX, req[0] && tgt0 > POS_MAX} : 2'b00;
    cnt_en = state == SEEK && en;
    cnt_up = state == SEEK && up;
    busy = state != IDLE;
  end
  // falling-edge state, position model, grant latch and round-robin pointer
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pos <= 3'd0;
      tgt <= 3'd0;
      own <= 1'b0;
      rr <= 1'b1;
      gcnt <= 3'd0;
    end else begin
      state <= nxt;
      if (cnt_en) pos <= cnt_up ? (pos == POS_MAX ? 3'd0 : pos + 3'd1) : (pos == 3'd0 ? POS_MAX : pos - 3'd1);
      if (state == IDLE && (e0 || e1)) begin
        own <= pick;
        tgt <= pick ? tgt1 : tgt0;
      end
      if (state == FIN || (state == SEEK && !req[own])) rr <= own;
      gcnt <= state == GAPW ? gcnt + 3'd1 : 3'd0;
    end
  end
endmodule

// File: doc/mod5_seek_arb.md
MOD5_SEEK_ARB -- requirements
Module: mod5_seek_arb

Interface
REQ-001 Parameter GAP, default 1, number of idle cycles (0..7) inserted after each completed or aborted request before the next grant.
REQ-002 clk  input  1  single clock; all state updates on the falling edge, matching the mod-5 counter it drives.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  2  per-requester seek request; level, held until done[i] or abort.
REQ-005 tgt0  input  3  requester 0 target position, valid range 0..4.
REQ-006 tgt1  input  3  requester 1 target position, valid range 0..4.
REQ-007 gnt  output  2  one-hot grant; at most one bit high.
REQ-008 done  output  2  one-cycle pulse: granted requester's target reached.
REQ-009 err  output  2  one-cycle pulse per IDLE cycle in which req[i] is high with tgt_i > 4.
REQ-010 cnt_en  output  1  enable to the mod-5 up/down counter.
REQ-011 cnt_up  output  1  direction to the counter: 1 = up, 0 = down.
REQ-012 pos  output  3  controller's model of the counter value, 0..4.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, SEEK, FIN and GAPW.
REQ-015 IDLE: the requester is eligible if req[i]=1 and tgt_i<=4; if any requester is eligible, the next edge SHALL latch its target, set gnt[i] and enter SEEK.
REQ-016 Arbitration SHALL be round-robin: with both eligible, the requester not served last wins; after reset requester 0 has priority.
REQ-017 An ineligible (invalid-target) requester SHALL get no grant and SHALL not change the round-robin pointer.
REQ-018 SEEK: cnt_en = (pos != target); cnt_up = 1 when (target-pos) mod 5 is 1 or 2, else 0. Both outputs are decoded from registered state only.
REQ-019 On each edge with cnt_en=1, pos SHALL step by +1 or -1 mod 5, with wrap-around 4->0 on up and 0->4 on down.
REQ-020 SEEK with pos==target SHALL go to FIN on the next edge. A seek SHALL take at most 2 counting cycles.
REQ-021 FIN SHALL last one cycle, with done[i]=1, gnt[i] still 1 and cnt_en=0. The round-robin pointer SHALL update to i, and the next state SHALL be GAPW, or IDLE when GAP=0.
REQ-022 GAPW SHALL hold gnt=0 and cnt_en=0 for GAP cycles, then enter IDLE.
REQ-023 Abort: if req[i] falls while in SEEK, the next edge SHALL enter GAPW (IDLE when GAP=0), clear gnt, emit no done, and still update the pointer. pos keeps any steps already taken.
REQ-024 Target inputs SHALL be sampled only at grant; changes during SEEK SHALL be ignored.
REQ-025 Latency from grant edge to done pulse SHALL be 1 + |shortest distance| cycles; a target equal to pos gives done one cycle after the grant.
REQ-026 cnt_en SHALL be 0 in every state except SEEK.

Reset
REQ-027 While rst=1: state=IDLE, pos=0, latched target=0, rr pointer=1 (requester 0 preferred), and gnt, done, err, cnt_en, cnt_up, busy all 0.
REQ-028 Reset asserted mid-SEEK SHALL force cnt_en low immediately (asynchronously); no done is emitted.

Structure
REQ-029 Shared package mod5_pkg SHALL hold the state encoding, the constant MOD=5, and the constant POS_MAX=4.
REQ-030 Direction and distance decode SHALL be one combinational sub-module, mod5_dir (inputs pos, target; outputs en, up); everything else stays in mod5_seek_arb.

Verification
REQ-031 Reset, then req=01 with tgt0=3 -> gnt=01; cnt_up=0 for 2 cycles (pos 0->4->3); done=01 on the next cycle; busy falls after GAP.
REQ-032 pos=4, req=10 with tgt1=1 -> up, wrapping 4->0->1; done=10 after 3 cycles.
REQ-033 Both requesters held continuously, tgt0=2 and tgt1=0 -> grants alternate 01,10,01,...; gnt is never two-hot.
REQ-034 pos=2, req=01 with tgt0=2 -> no cnt_en pulse; done=01 one cycle after the grant.
REQ-035 req=01 with tgt0=6 -> err=01 every IDLE cycle and no grant; req1 with tgt1=1 is still served.
REQ-036 req0 dropped after 1 step toward 3 from 0 -> pos=4, no done, next grant after GAP; rst pulsed mid-SEEK -> cnt_en=0 at once and pos=0.
